// File: rtl/rv2t_reg_file_mp_pkg.sv
// rtl/rv2t_reg_file_mp_pkg.sv - shared RV2T widths and register-file state encoding
package rv2t_reg_file_mp_pkg;

  localparam int RV2T_XLEN          = 32;
  localparam int RV2T_REG_ADDR_BITS = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rv2t_reg_file_mp_if.sv
// rtl/rv2t_reg_file_mp_if.sv - read/write/control bundle of the multi-port register file
interface rv2t_reg_file_mp_if
  import rv2t_reg_file_mp_pkg::*;
#(
  parameter int XLEN           = RV2T_XLEN,
  parameter int REG_ADDR_BITS  = RV2T_REG_ADDR_BITS,
  parameter int NUM_READ_PORTS = 2
) ();

  logic                                    sync_reset;
  logic                                    read_enable;
  logic [NUM_READ_PORTS*REG_ADDR_BITS-1:0] read_addr;
  logic                                    read_en_out;
  logic [NUM_READ_PORTS*XLEN-1:0]          read_data_out;
  logic                                    write_enable;
  logic [REG_ADDR_BITS-1:0]                write_addr;
  logic [XLEN-1:0]                         write_data_in;
  logic                                    init_busy;

  modport master (
    output sync_reset, read_enable, read_addr, write_enable, write_addr, write_data_in,
    input  read_en_out, read_data_out, init_busy
  );

  modport slave (
    input  sync_reset, read_enable, read_addr, write_enable, write_addr, write_data_in,
    output read_en_out, read_data_out, init_busy
  );

endinterface

// File: rtl/rv2t_reg_file_mp_dual_port_ram.sv
// rtl/rv2t_reg_file_mp_dual_port_ram.sv - simple dual-port RAM, registered read-before-write
module rv2t_reg_file_mp_dual_port_ram #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  wclk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  rclk,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [1<<ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge wclk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // A same-edge write is not visible here; the top decides on forwarding.
  always_ff @(posedge rclk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rv2t_reg_file_mp.sv
// rtl/rv2t_reg_file_mp.sv - multi-read-port register file with clear sweep and write bypass
module rv2t_reg_file_mp
  import rv2t_reg_file_mp_pkg::*;
#(
  parameter int XLEN           = RV2T_XLEN,
  parameter int REG_ADDR_BITS  = RV2T_REG_ADDR_BITS,
  parameter int NUM_READ_PORTS = 2,
  parameter int ZERO_REG_EN    = 1,
  parameter int BYPASS_EN      = 1
) (
  input  logic               clk,
  input  logic               reset,
  rv2t_reg_file_mp_if.slave  bus
);

  localparam logic [REG_ADDR_BITS-1:0] LAST_ADDR = {REG_ADDR_BITS{1'b1}};

  rf_state_e                     state_q, state_d;
  logic [REG_ADDR_BITS-1:0]      cnt_q, cnt_d;
  logic                          is_ready;
  logic                          accept_rd;
  logic                          accept_wr;
  logic                          wr_to_zero;
  logic                          ram_we;
  logic [REG_ADDR_BITS-1:0]      ram_waddr;
  logic [XLEN-1:0]               ram_wdata;
  logic                          rd_valid_q;
  logic                          has_data_q;
  logic [XLEN-1:0]               wdata_q;
  logic [NUM_READ_PORTS-1:0]     hit_q;
  logic [REG_ADDR_BITS-1:0]      raddr_q [NUM_READ_PORTS];
  logic [NUM_READ_PORTS*XLEN-1:0] rdata_all;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.sync_reset) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) state_d = ST_READY;
        end
        default: state_d = ST_READY;
      endcase
    end
  end

  assign is_ready   = (state_q == ST_READY);
  assign wr_to_zero = (ZERO_REG_EN != 0) && (bus.write_addr == '0);
  // A pending sync_reset already belongs to the sweep, so nothing is accepted.
  assign accept_rd  = is_ready && bus.read_enable && !bus.sync_reset;
  assign accept_wr  = is_ready && bus.write_enable && !bus.sync_reset && !wr_to_zero;

  assign ram_we    = !is_ready || accept_wr;
  assign ram_waddr = is_ready ? bus.write_addr : cnt_q;
  assign ram_wdata = is_ready ? bus.write_data_in : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      has_data_q <= 1'b0;
      wdata_q    <= '0;
      hit_q      <= '0;
      for (int k = 0; k < NUM_READ_PORTS; k++) raddr_q[k] <= '0;
    end else begin
      rd_valid_q <= accept_rd;
      if (!is_ready) has_data_q <= 1'b0;
      else if (accept_rd) has_data_q <= 1'b1;
      if (accept_rd) begin
        wdata_q <= bus.write_data_in;
        for (int k = 0; k < NUM_READ_PORTS; k++) begin
          raddr_q[k] <= bus.read_addr[k*REG_ADDR_BITS +: REG_ADDR_BITS];
          hit_q[k]   <= accept_wr &&
                        (bus.write_addr == bus.read_addr[k*REG_ADDR_BITS +: REG_ADDR_BITS]);
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_port
    logic [XLEN-1:0] ram_rdata;
    logic [XLEN-1:0] port_data;

    rv2t_reg_file_mp_dual_port_ram #(
      .ADDR_WIDTH (REG_ADDR_BITS),
      .DATA_WIDTH (XLEN)
    ) u_ram (
      .wclk    (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .rclk    (clk),
      .re_i    (accept_rd),
      .raddr_i (bus.read_addr[k*REG_ADDR_BITS +: REG_ADDR_BITS]),
      .rdata_o (ram_rdata)
    );

    // Zero-register masking wins over forwarding; nothing is shown outside READY.
    always_comb begin
      port_data = ram_rdata;
      if ((BYPASS_EN != 0) && hit_q[k]) port_data = wdata_q;
      if ((ZERO_REG_EN != 0) && (raddr_q[k] == '0)) port_data = '0;
      if (!has_data_q || !is_ready) port_data = '0;
    end

    assign rdata_all[k*XLEN +: XLEN] = port_data;
  end

  assign bus.read_data_out = rdata_all;
  assign bus.read_en_out   = rd_valid_q;
  assign bus.init_busy     = !is_ready;

endmodule

// File: doc/rv2t_reg_file_mp.md
RV2T_REG_FILE_MP -- requirements
Module: RV2T_reg_file_mp

Interface
REQ-001 Parameter XLEN, default 32: register data width in bits.
REQ-002 Parameter REG_ADDR_BITS, default 5: register address width; depth = 2**REG_ADDR_BITS.
REQ-003 Parameter NUM_READ_PORTS, default 2, range 1..4: count of independent read ports.
REQ-004 Parameter ZERO_REG_EN, default 1: register 0 hardwired to zero when 1.
REQ-005 Parameter BYPASS_EN, default 1: same-cycle write-to-read forwarding enabled when 1.
REQ-006 clk  in  1: sole clock, all state on rising edge.
REQ-007 reset  in  1: asynchronous, active-high reset.
REQ-008 sync_reset  in  1: synchronous request to restart the clear sweep.
REQ-009 read_enable  in  1: read request, all ports simultaneously.
REQ-010 read_addr  in  NUM_READ_PORTS*REG_ADDR_BITS: packed read addresses, port k at bits [k*REG_ADDR_BITS +: REG_ADDR_BITS].
REQ-011 read_en_out  out  1: read data valid, one cycle after an accepted read_enable.
REQ-012 read_data_out  out  NUM_READ_PORTS*XLEN: packed read data, port k at bits [k*XLEN +: XLEN].
REQ-013 write_enable  in  1: write request.
REQ-014 write_addr  in  REG_ADDR_BITS: write address.
REQ-015 write_data_in  in  XLEN: write data.
REQ-016 init_busy  out  1: clear sweep in progress; reads and writes are not accepted.

Function
REQ-017 State machine: two states, CLEAR and READY; reset enters CLEAR with clear counter = 0.
REQ-018 CLEAR: write 0 to address = counter on every read-port RAM each cycle, increment counter; at counter = 2**REG_ADDR_BITS-1 write, go READY next cycle.
REQ-019 Sweep duration: exactly 2**REG_ADDR_BITS cycles; init_busy = 1 throughout CLEAR, 0 in READY.
REQ-020 sync_reset = 1 in any state: next state CLEAR, counter = 0; sync_reset during CLEAR restarts the sweep from 0.
REQ-021 In CLEAR: write_enable and read_enable are ignored; read_en_out = 0; read_data_out = 0.
REQ-022 In READY: write_enable = 1 writes write_data_in to write_addr in all read-port RAMs at the clock edge.
REQ-023 ZERO_REG_EN = 1: writes to address 0 are discarded; any read of address 0 returns 0 regardless of bypass.
REQ-024 Read latency: read_en_out and read_data_out are valid exactly 1 cycle after read_enable = 1 in READY; read_en_out = 0 otherwise.
REQ-025 Read addresses and write-hit flags are registered with the read; read_data_out is held stable while no new read is accepted.
REQ-026 BYPASS_EN = 1: if a read of address A and a write to A (A nonzero or ZERO_REG_EN = 0) are in the same cycle, the port returns the new write data next cycle.
REQ-027 BYPASS_EN = 0: the same collision returns the previous register contents.
REQ-028 Multiple ports reading the same address in the same cycle return identical data.
REQ-029 Bypass comparison uses the registered write address and data of the colliding cycle, never the current-cycle write_addr.

Reset
REQ-030 On reset = 1: state CLEAR, counter = 0, init_busy = 1, read_en_out = 0, read_data_out = 0, bypass registers = 0.
REQ-031 Reset asserted mid-sweep or mid-read aborts immediately; after release the full sweep reruns from address 0.
REQ-032 RAM contents are not reset directly; the sweep guarantees all-zero contents before READY.

Structure
REQ-033 XLEN and REG_ADDR_BITS defaults and the state encoding (CLEAR, READY) shall come from the shared RV2T common header/package.
REQ-034 One dual_port_ram instance per read port (generate loop), ADDR_WIDTH = REG_ADDR_BITS, DATA_WIDTH = XLEN, wclk = rclk = clk, write port driven by the sweep or normal write mux.
REQ-035 Bypass/zero logic per port sits in the same generate loop; no other sub-modules.

Verification
REQ-036 Release reset -> init_busy = 1 for exactly 32 cycles (default params), then 0; read of each of 0..31 returns 0x00000000.
REQ-037 Write 0xDEADBEEF to x5, later read ports (5, 5) -> both ports return 0xDEADBEEF one cycle later with read_en_out = 1.
REQ-038 Same cycle: write 0x12345678 to x7 and read x7 on port 0 -> BYPASS_EN = 1 returns 0x12345678; BYPASS_EN = 0 returns the prior value 0x0.
REQ-039 Write 0xFFFFFFFF to x0, read x0 in the same cycle and later -> 0x00000000 both times (ZERO_REG_EN = 1).
REQ-040 Pulse sync_reset at sweep cycle 10 -> init_busy remains 1 for 32 further cycles; writes issued during the sweep have no effect.
REQ-041 NUM_READ_PORTS = 4, XLEN = 64: fill x1..x31 with unique values, read 4 distinct addresses per cycle -> all ports return correct values at latency 1.
